// File: rtl/wdt_kicker.sv
// Watchdog feeder: periodically writes the KEY1/KEY2 unlock-then-kick pair to the
// watchdog, honours a software hold, and tracks kick/reset/timeout status.
module wdt_kicker #(
    parameter int                PERIOD_W = 24,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] KEY1     = 16'h600d,
    parameter logic [DATA_W-1:0] KEY2     = 16'hc0de,
    parameter int                ACK_TO   = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                hold,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clr,
    output logic                wr_valid,
    output logic [DATA_W-1:0]   wr_data,
    input  logic                wr_ready,
    input  logic                wdt_reset,
    output logic [15:0]         kick_count,
    output logic                reset_seen,
    output logic                timeout_err,
    output logic                busy
);

    localparam int ACK_W = (ACK_TO > 1) ? $clog2(ACK_TO + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_KEY1 = 2'd2,
        ST_KEY2 = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [ACK_W-1:0]    ack_q, ack_d;
    logic [PERIOD_W-1:0] reload;
    logic                hs;
    logic                kick_evt;
    logic                tout_evt;

    // period of 0 is treated as 1, so the reload value never underflows
    assign reload = (period == '0) ? '0 : period - 1'b1;

    // Write channel: a word transfers on every rising edge where wr_valid and wr_ready
    // are both high; once raised, wr_valid and wr_data hold until that transfer or an abort.
    assign hs = wr_valid && wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        kick_evt = 1'b0;
        tout_evt = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        busy     = 1'b0;

        case (state_q)
            ST_KEY1: begin
                wr_valid = 1'b1;
                wr_data  = KEY1;
                busy     = 1'b1;
            end
            ST_KEY2: begin
                wr_valid = 1'b1;
                wr_data  = KEY2;
                busy     = 1'b1;
            end
            default: ;
        endcase

        // A watchdog reset overrides everything, including a same-cycle handshake or timeout
        if (wdt_reset) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d = ST_WAIT;
                        cnt_d   = reload;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!hold) begin
                        state_d = ST_KEY1;
                    end
                end
                ST_KEY1, ST_KEY2: begin
                    if (hs) begin
                        if (state_q == ST_KEY1) begin
                            state_d = ST_KEY2;
                        end else begin
                            // enable is only consulted once the pair is complete
                            kick_evt = 1'b1;
                            state_d  = enable ? ST_WAIT : ST_IDLE;
                            cnt_d    = reload;
                        end
                    end else if (ack_q == ACK_W'(ACK_TO - 1)) begin
                        tout_evt = 1'b1;
                        state_d  = ST_WAIT;
                        cnt_d    = reload;
                    end else begin
                        ack_d = ack_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sticky status; a set event in the same cycle beats clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kick_count  <= '0;
            reset_seen  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (wdt_reset) begin
                reset_seen <= 1'b1;
            end else if (clr) begin
                reset_seen <= 1'b0;
            end

            if (tout_evt) begin
                timeout_err <= 1'b1;
            end else if (clr) begin
                timeout_err <= 1'b0;
            end

            if (kick_evt) begin
                if (kick_count != 16'hffff) begin
                    kick_count <= kick_count + 16'd1;
                end
            end else if (clr) begin
                kick_count <= '0;
            end
        end
    end

endmodule
